// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the multi-port register file: default sizes, the
// hard-wired zero register index and the address-width helper.
package regfile_mp_sb_pkg;

   localparam int unsigned DEF_XLEN = 32;
   localparam int unsigned DEF_NREG = 32;
   localparam int unsigned ZERO_IDX = 0;

   function automatic int unsigned rf_aw(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_mp_sb_rd.sv
// One read port: stored-value select, highest-index writeback bypass,
// operand-ready generation and zero-register override.
module regfile_mp_sb_rd
   import regfile_mp_sb_pkg::*;
#(
   parameter int unsigned XLEN     = DEF_XLEN,
   parameter int unsigned NREG     = DEF_NREG,
   parameter int unsigned NWR      = 2,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1,
   localparam int unsigned AW      = rf_aw(NREG)
)(
   input  logic                       byp_en_i,
   input  logic [AW-1:0]              rd_addr_i,
   input  logic [NREG-1:0][XLEN-1:0]  regs_i,
   input  logic [NREG-1:0]            busy_i,
   input  logic [NWR-1:0]             wr_en_i,
   input  logic [NWR*AW-1:0]          wr_addr_i,
   input  logic [NWR*XLEN-1:0]        wr_data_i,
   output logic [XLEN-1:0]            rd_data_o,
   output logic                       rd_rdy_o
);

   logic hit;

   always_comb begin
      hit       = 1'b0;
      rd_data_o = regs_i[rd_addr_i];
      // Ascending scan so the highest-index matching port wins, like the write path.
      for (int unsigned j = 0; j < NWR; j++) begin
         if (BYPASS && byp_en_i && wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
            hit       = 1'b1;
            rd_data_o = wr_data_i[j*XLEN +: XLEN];
         end
      end
      rd_rdy_o = !busy_i[rd_addr_i] || hit;
      if (ZERO_REG && (rd_addr_i == AW'(ZERO_IDX))) begin
         rd_data_o = '0;
         rd_rdy_o  = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with writeback bypass and per-register
// busy scoreboard (issue marks busy, writeback clears it).
module regfile_mp_sb
   import regfile_mp_sb_pkg::*;
#(
   parameter int unsigned XLEN     = DEF_XLEN,
   parameter int unsigned NREG     = DEF_NREG,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 2,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1,
   localparam int unsigned AW      = rf_aw(NREG)
)(
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic [NRD*AW-1:0]    Rs_Addr,
   output logic [NRD*XLEN-1:0]  Rs_Data,
   output logic [NRD-1:0]       Rs_Rdy,
   input  logic [NWR-1:0]       Wr_En,
   input  logic [NWR*AW-1:0]    Wr_Addr,
   input  logic [NWR*XLEN-1:0]  Wr_Data,
   input  logic                 Iss_En,
   input  logic [AW-1:0]        Iss_Rd,
   output logic [NREG-1:0]      Busy_Vec
);

   logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
   logic [NREG-1:0]           busy_q, busy_d;
   logic [AW-1:0]             waddr;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      waddr  = '0;
      // Later ports overwrite earlier ones, giving highest-index priority on conflicts.
      for (int unsigned j = 0; j < NWR; j++) begin
         waddr = Wr_Addr[j*AW +: AW];
         if (Wr_En[j] && !(ZERO_REG && (waddr == AW'(ZERO_IDX)))) begin
            regs_d[waddr] = Wr_Data[j*XLEN +: XLEN];
            busy_d[waddr] = 1'b0;
         end
      end
      // Applied after clears: a same-cycle issue names a new producer.
      if (Iss_En && !(ZERO_REG && (Iss_Rd == AW'(ZERO_IDX)))) begin
         busy_d[Iss_Rd] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign Busy_Vec = busy_q;

   // Bypass is suppressed in reset since those writes are discarded.
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      regfile_mp_sb_rd #(
         .XLEN     (XLEN),
         .NREG     (NREG),
         .NWR      (NWR),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .byp_en_i  (rst_n),
         .rd_addr_i (Rs_Addr[k*AW +: AW]),
         .regs_i    (regs_q),
         .busy_i    (busy_q),
         .wr_en_i   (Wr_En),
         .wr_addr_i (Wr_Addr),
         .wr_data_i (Wr_Data),
         .rd_data_o (Rs_Data[k*XLEN +: XLEN]),
         .rd_rdy_o  (Rs_Rdy[k])
      );
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised self-checking bench for regfile_mp_sb: a BYPASS=1 and a BYPASS=0
// instance share stimulus and are compared against an array/scoreboard model.
module tb_regfile_mp_sb;

   localparam int XL  = 32;
   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic                CLK = 1'b0;
   logic                rst_n;
   logic [NRD*AW-1:0]   Rs_Addr;
   logic [NRD*XL-1:0]   Rs_Data, Rs_Data_nb;
   logic [NRD-1:0]      Rs_Rdy, Rs_Rdy_nb;
   logic [NWR-1:0]      Wr_En;
   logic [NWR*AW-1:0]   Wr_Addr;
   logic [NWR*XL-1:0]   Wr_Data;
   logic                Iss_En;
   logic [AW-1:0]       Iss_Rd;
   logic [NR-1:0]       Busy_Vec, Busy_Vec_nb;

   always #5 CLK = ~CLK;

   regfile_mp_sb #(.XLEN(XL), .NREG(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut (
      .CLK(CLK), .rst_n(rst_n), .Rs_Addr(Rs_Addr), .Rs_Data(Rs_Data), .Rs_Rdy(Rs_Rdy),
      .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Iss_En(Iss_En), .Iss_Rd(Iss_Rd),
      .Busy_Vec(Busy_Vec));

   regfile_mp_sb #(.XLEN(XL), .NREG(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_nb (
      .CLK(CLK), .rst_n(rst_n), .Rs_Addr(Rs_Addr), .Rs_Data(Rs_Data_nb), .Rs_Rdy(Rs_Rdy_nb),
      .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Iss_En(Iss_En), .Iss_Rd(Iss_Rd),
      .Busy_Vec(Busy_Vec_nb));

   // Reference state: architectural values and pending-producer flags.
   logic [XL-1:0] m_mem [NR];
   bit            m_busy[NR];
   int            checks   = 0;
   int            failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NR-1:0] model_busy_vec();
      logic [NR-1:0] v;
      for (int r = 0; r < NR; r++) v[r] = m_busy[r];
      return v;
   endfunction

   // Expected {rdy, data} for read port k from the architectural rules.
   function automatic logic [XL:0] exp_rd(input int k, input bit byp);
      int            a;
      logic [XL-1:0] d;
      bit            hit;
      a   = int'(Rs_Addr[k*AW +: AW]);
      hit = 0;
      if (!rst_n || a == 0) return {1'b1, {XL{1'b0}}};
      d = m_mem[a];
      for (int j = 0; j < NWR; j++) begin
         if (Wr_En[j] && int'(Wr_Addr[j*AW +: AW]) == a) begin
            hit = 1;
            if (byp) d = Wr_Data[j*XL +: XL];
         end
      end
      return {(!m_busy[a]) || (byp && hit), d};
   endfunction

   task automatic check_reads();
      logic [XL:0] e;
      for (int k = 0; k < NRD; k++) begin
         e = exp_rd(k, 1'b1);
         chk($sformatf("rd%0d_data", k), 64'(Rs_Data[k*XL +: XL]), 64'(e[XL-1:0]));
         chk($sformatf("rd%0d_rdy", k), 64'(Rs_Rdy[k]), 64'(e[XL]));
         e = exp_rd(k, 1'b0);
         chk($sformatf("nb_rd%0d_data", k), 64'(Rs_Data_nb[k*XL +: XL]), 64'(e[XL-1:0]));
         chk($sformatf("nb_rd%0d_rdy", k), 64'(Rs_Rdy_nb[k]), 64'(e[XL]));
      end
   endtask

   // Edge update: the last enabled port to a register supplies its value.
   task automatic model_edge();
      bit set, clr;
      if (!rst_n) return;
      for (int r = 1; r < NR; r++) begin
         set = Iss_En && int'(Iss_Rd) == r;
         clr = 0;
         for (int j = 0; j < NWR; j++) begin
            if (Wr_En[j] && int'(Wr_Addr[j*AW +: AW]) == r) begin
               clr      = 1;
               m_mem[r] = Wr_Data[j*XL +: XL];
            end
         end
         if (set)      m_busy[r] = 1;
         else if (clr) m_busy[r] = 0;
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NR; r++) begin
         m_mem[r]  = '0;
         m_busy[r] = 0;
      end
   endtask

   // Called just after a falling edge with inputs driven.
   task automatic cycle();
      #1 check_reads();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      chk("busy_vec", 64'(Busy_Vec), 64'(model_busy_vec()));
      chk("busy_vec_nb", 64'(Busy_Vec_nb), 64'(model_busy_vec()));
   endtask

   task automatic idle();
      Rs_Addr = '0; Wr_En = '0; Wr_Addr = '0; Wr_Data = '0; Iss_En = 1'b0; Iss_Rd = '0;
   endtask

   task automatic set_wr(input int j, input int a, input logic [XL-1:0] d);
      Wr_En[j]            = 1'b1;
      Wr_Addr[j*AW +: AW] = AW'(a);
      Wr_Data[j*XL +: XL] = d;
   endtask

   task automatic set_rd(input int k, input int a);
      Rs_Addr[k*AW +: AW] = AW'(a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      idle();
      rst_n = 1'b0;

      // Reset held: writes ignored, reads 0 and ready, nothing busy.
      @(negedge CLK);
      set_wr(0, 5, 32'hCAFE_0001); set_wr(1, 6, 32'hCAFE_0002);
      Iss_En = 1'b1; Iss_Rd = 5'd7;
      set_rd(0, 5); set_rd(1, 6);
      cycle();
      #1 chk("rst_rd0", 64'(Rs_Data[0 +: XL]), 64'h0);
      chk("rst_rdy", 64'(Rs_Rdy), 64'h3);
      chk("rst_busy", 64'(Busy_Vec), 64'h0);
      idle(); set_rd(0, 5); set_rd(1, 6);
      rst_n = 1'b1;
      cycle();

      // Write then read back.
      idle(); set_wr(0, 5, 32'hDEAD_BEEF);
      cycle();
      idle(); set_rd(0, 5);
      #1 chk("wr_rd5", 64'(Rs_Data[0 +: XL]), 64'hDEAD_BEEF);
      chk("wr_rdy5", 64'(Rs_Rdy[0]), 64'h1);
      cycle();

      // Same-cycle bypass vs stale read.
      idle(); set_wr(0, 7, 32'h1234); set_rd(1, 7);
      #1 chk("byp_rd7", 64'(Rs_Data[XL +: XL]), 64'h1234);
      chk("nobyp_rd7", 64'(Rs_Data_nb[XL +: XL]), 64'h0);
      cycle();

      // Write conflict: port 1 wins, bypass agrees.
      idle(); set_wr(0, 3, 32'hA); set_wr(1, 3, 32'hB); set_rd(0, 3);
      #1 chk("conf_byp", 64'(Rs_Data[0 +: XL]), 64'hB);
      cycle();
      idle(); set_rd(0, 3); set_rd(1, 3);
      #1 chk("conf_x3", 64'(Rs_Data_nb[0 +: XL]), 64'hB);
      cycle();

      // Scoreboard: issue, writeback clear, issue+writeback same cycle.
      idle(); Iss_En = 1'b1; Iss_Rd = 5'd9;
      cycle();
      chk("sb_busy9", 64'(Busy_Vec[9]), 64'h1);
      idle(); set_rd(0, 9);
      #1 chk("sb_rdy9", 64'(Rs_Rdy[0]), 64'h0);
      cycle();
      idle(); set_rd(0, 9); set_wr(1, 9, 32'h99);
      #1 chk("sb_wb_rdy", 64'(Rs_Rdy[0]), 64'h1);
      chk("sb_wb_rdy_nb", 64'(Rs_Rdy_nb[0]), 64'h0);
      cycle();
      chk("sb_clr9", 64'(Busy_Vec[9]), 64'h0);
      idle(); Iss_En = 1'b1; Iss_Rd = 5'd9; set_wr(0, 9, 32'h77);
      cycle();
      chk("sb_iss_wins", 64'(Busy_Vec[9]), 64'h1);

      // Zero register.
      idle(); set_wr(1, 0, 32'hFFFF); Iss_En = 1'b1; Iss_Rd = 5'd0; set_rd(0, 0); set_rd(1, 0);
      #1 chk("zr_byp", 64'(Rs_Data[0 +: XL]), 64'h0);
      cycle();
      idle(); set_rd(0, 0);
      #1 chk("zr_rd", 64'(Rs_Data[0 +: XL]), 64'h0);
      chk("zr_rdy", 64'(Rs_Rdy[0]), 64'h1);
      chk("zr_busy", 64'(Busy_Vec[0]), 64'h0);
      cycle();

      // Asynchronous reset with regs 4 and 9 pending.
      idle(); Iss_En = 1'b1; Iss_Rd = 5'd4;
      cycle();
      chk("ar_busy_pre", 64'(Busy_Vec & 32'h0000_0210), 64'h210);
      idle(); set_rd(0, 5);
      #2 rst_n = 1'b0;
      #1 chk("ar_busy", 64'(Busy_Vec), 64'h0);
      chk("ar_busy_nb", 64'(Busy_Vec_nb), 64'h0);
      chk("ar_data", 64'(Rs_Data[0 +: XL]), 64'h0);
      model_reset();
      @(negedge CLK);
      rst_n = 1'b1;

      // Random traffic, addresses biased low to force collisions.
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int k = 0; k < NRD; k++)
            set_rd(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR-1) : $urandom_range(0, 7));
         for (int j = 0; j < NWR; j++)
            if ($urandom_range(0, 1) == 1)
               set_wr(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR-1) : $urandom_range(0, 7), $urandom);
         Iss_En = 1'($urandom_range(0, 1));
         Iss_Rd = AW'($urandom_range(0, 7));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
